// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, sampling points and receiver FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned UART_OVERSAMPLE  = 16;
  localparam int unsigned UART_MID_SAMPLE  = 7;
  localparam logic        UART_PARITY_SEED = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous, idle-high input; resets to 1.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain; reset to the line's idle level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start, 8 data bits LSB-first, optional odd
// parity, one stop bit. Parity is enabled by defining UART_RX_PARITY_EN; with
// it undefined the frame is 10 bits and parityerr is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       mclkx16,
  input  logic       reset,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] data,
  output logic       rxrdy,
  output logic       parityerr,
  output logic       framingerr,
  output logic       overrun
);

  localparam logic [3:0] SCNT_MID  = 4'(UART_MID_SAMPLE);
  localparam logic [3:0] SCNT_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] BCNT_LAST = 3'(UART_DATA_BITS - 1);

  logic                      w_rxs;
  logic                      r_rxs_d;
  rx_state_t                 r_state;
  rx_state_t                 w_state_nxt;
  logic [3:0]                r_scnt;
  logic [2:0]                r_bcnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_scnt_clr;
  logic                      w_bcnt_clr;
  logic                      w_data_smp;
  logic                      w_load;
`ifdef UART_RX_PARITY_EN
  logic                      w_par_smp;
  logic                      r_par;
  logic                      r_parityerr;
`endif

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .i_clk(mclkx16),
    .i_rst(reset),
    .i_d  (rx),
    .o_q  (w_rxs)
  );

  // Previous synchronized line value for falling-edge detection in IDLE.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_rxs_d <= 1'b1;
    end else begin
      r_rxs_d <= w_rxs;
    end
  end

  // FSM state register.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle sampling strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_clr  = 1'b0;
    w_bcnt_clr  = 1'b0;
    w_data_smp  = 1'b0;
    w_load      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_smp   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rxs && r_rxs_d) begin
          w_scnt_clr  = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_scnt == SCNT_MID) begin
          if (w_rxs) begin
            w_state_nxt = IDLE;
          end else begin
            w_scnt_clr  = 1'b1;
            w_bcnt_clr  = 1'b1;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (r_scnt == SCNT_LAST) begin
          w_data_smp = 1'b1;
          if (r_bcnt == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (r_scnt == SCNT_LAST) begin
          w_par_smp   = 1'b1;
          w_state_nxt = STOP;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (r_scnt == SCNT_LAST) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample counter: free-runs outside IDLE, wraps every bit period.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_scnt <= '0;
    end else if (w_scnt_clr) begin
      r_scnt <= '0;
    end else if (r_state != IDLE) begin
      r_scnt <= r_scnt + 4'd1;
    end
  end

  // Bit counter: counts data samples within a frame.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
    end else if (w_bcnt_clr) begin
      r_bcnt <= '0;
    end else if (w_data_smp) begin
      r_bcnt <= r_bcnt + 3'd1;
    end
  end

  // Shift register: new sample enters at the MSB so the byte lands LSB-first.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_data_smp) begin
      r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity accumulator: seeded at start, folds in data and parity samples;
  // a final value of 1 means the received ones count was even (error).
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_bcnt_clr) begin
      r_par <= UART_PARITY_SEED;
    end else if (w_data_smp || w_par_smp) begin
      r_par <= r_par ^ w_rxs;
    end
  end

  // Parity error flag: written on load, cleared by read; load wins a tie.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      r_parityerr <= 1'b0;
    end else if (w_load) begin
      r_parityerr <= r_par;
    end else if (read) begin
      r_parityerr <= 1'b0;
    end
  end

  assign parityerr = r_parityerr;
`else
  assign parityerr = 1'b0;
`endif

  // Receive hold register and status; a load takes priority over read.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      data       <= '0;
      rxrdy      <= 1'b0;
      framingerr <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_load) begin
      data       <= r_shift;
      rxrdy      <= 1'b1;
      framingerr <= ~w_rxs;
      overrun    <= rxrdy & ~read;
    end else if (read) begin
      rxrdy      <= 1'b0;
      framingerr <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
